dm_bus_arbiter: RTL
===================

Name: dm_bus_arbiter

Overview:
Two-master arbiter and sequencer for the single data-memory/bridge port.
- Master 0 is the CPU MEM-stage access: address, write data and byte enables.
- Master 1 is a secondary bus master, such as a DMA or debug loader.
- The block serialises accesses, runs a fixed-latency transaction against the slave, returns read data, and produces the CPU stall that holds the pipeline until its access completes.

Parameters:
LATENCY, 2, slave cycles from address issue to valid mem_rdata; legal range 1..15.
CNT_W, 4, width of the latency down-counter.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
m0_req  input  1  CPU access request, level
m0_addr  input  32  CPU byte address
m0_wdata  input  32  CPU write data
m0_byteen  input  4  CPU byte enables; nonzero means write, 0 means read
m0_ack  output  1  one-cycle completion pulse to CPU
m0_rdata  output  32  read data, valid while m0_ack=1
m0_stall  output  1  CPU pipeline hold
m1_req  input  1  secondary master request, level
m1_addr  input  32  secondary byte address
m1_wdata  input  32  secondary write data
m1_byteen  input  4  secondary byte enables
m1_ack  output  1  one-cycle completion pulse to secondary master
m1_rdata  output  32  read data, valid while m1_ack=1
mem_en  output  1  slave access active
mem_addr  output  32  slave address
mem_wdata  output  32  slave write data
mem_byteen  output  4  slave byte enables; nonzero only during the first access cycle
mem_rdata  input  32  slave read data
grant_id  output  1  owner of current transaction (0=CPU, 1=secondary)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, last_grant=1 (so the CPU wins the first tie).
  - All outputs 0: m*_ack, m*_rdata, mem_en, mem_addr, mem_wdata, mem_byteen, grant_id.
  - m0_stall is combinational and equals m0_req while held in reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled in IDLE only.
  - Only one request asserted: grant it.
  - Both asserted: grant the master that is not last_grant (round robin).
  - On grant: latch that master's addr, wdata and byteen, plus grant_id; load counter=LATENCY-1; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr and mem_wdata come from the latched registers.
  - mem_byteen = latched byteen on the first ACCESS cycle only, 0 afterwards, so each write commits exactly once.
  - counter>0: decrement.
  - counter==0: capture mem_rdata into the rdata register, go to RESP.
- RESP:
  - mem_en=0.
  - Assert ack for grant_id for exactly one cycle; the matching m*_rdata shows the captured data, the other rdata holds 0.
  - For writes, rdata is the captured slave value and has no meaning.
  - Set last_grant=grant_id; go to IDLE.
- Requests are level; the master deasserts req in the cycle after it sees its ack. A req still high in IDLE is a new transaction.
- Latency: request sampled in IDLE at cycle T gives ack at cycle T+LATENCY+1.
- Minimum spacing between consecutive transactions is LATENCY+2 cycles.
- m0_stall = m0_req & ~m0_ack, combinational, so the CPU advances in the ack cycle.
- Inputs may change after grant; only latched values reach the slave.
- Reset during ACCESS or RESP:
  - Transaction is abandoned immediately; no ack is issued.
  - A write whose first ACCESS cycle has already passed has committed. A write reset before that cycle has not.
- LATENCY=1: ACCESS lasts one cycle and capture happens in that cycle.

Optional Feature:
Macro DM_ARB_FIXED_PRIO_EN.
- Defined: the CPU (m0) always wins a simultaneous request and last_grant is ignored for arbitration. The secondary master can starve while the CPU requests continuously.
- Undefined: round robin as described above.

Test Plan:
1. LATENCY=2, m0 read at 0x0000_3000 with slave returning 0xDEAD_BEEF: request sampled at cycle 1, mem_en at cycles 2-3, m0_ack=1 with m0_rdata=0xDEAD_BEEF at cycle 4, m0_stall=1 for cycles 1-3.
2. m0 and m1 assert together from reset: m0 is granted first (grant_id=0), then m1 (grant_id=1), with acks 4 cycles apart.
3. Both masters hold req continuously for 6 transactions: grant_id alternates 0,1,0,1,0,1.
4. m1 write addr=0x10, wdata=0x1234_5678, byteen=4'b0011: mem_byteen=4'b0011 in the first ACCESS cycle only, then 0; m1_ack 1 cycle; m0_ack stays 0.
5. reset=0 applied mid-ACCESS: mem_en, acks and rdata are 0 that cycle, state is IDLE; after reset=1 with m0_req high, a fresh transaction completes normally.
6. With DM_ARB_FIXED_PRIO_EN defined and both reqs held: grant_id stays 0 for every transaction and m1_ack never asserts.

Source files
------------

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter/sequencer for the data-memory port (m0=CPU, m1=secondary); build option DM_ARB_FIXED_PRIO_EN gives m0 strict priority.
// Latency: request sampled in IDLE at cycle T is acked at cycle T+LATENCY+1; transactions are spaced LATENCY+2 cycles apart.
// Backpressure: requests are level-held until ack; m0_stall holds the CPU pipeline until its ack cycle.
module dm_bus_arbiter #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_id_q, grant_id_d;
    logic             first_q, first_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       byteen_q, byteen_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             pick_m1;

    // Arbitration: a lone request wins; on a tie round robin (or m0 when fixed priority is built in).
    always_comb begin
        pick_m1 = m1_req;
        if (m0_req && m1_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            pick_m1 = 1'b0;
`else
            pick_m1 = ~last_grant_q;
`endif
        end
    end

    // Sequencer: latch the winner in IDLE, count down slave latency in ACCESS, ack in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        first_d      = first_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        byteen_d     = byteen_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_id_d = pick_m1;
                    addr_d     = pick_m1 ? m1_addr   : m0_addr;
                    wdata_d    = pick_m1 ? m1_wdata  : m0_wdata;
                    byteen_d   = pick_m1 ? m1_byteen : m0_byteen;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    first_d    = 1'b1;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Byte enables are presented once so a write commits exactly once.
                first_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            first_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            byteen_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            first_q      <= first_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            byteen_q     <= byteen_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them in the same cycle.
    assign mem_en     = (state_q == ST_ACCESS);
    assign mem_addr   = mem_en ? addr_q  : '0;
    assign mem_wdata  = mem_en ? wdata_q : '0;
    assign mem_byteen = (mem_en && first_q) ? byteen_q : '0;
    assign m0_ack     = (state_q == ST_RESP) && !grant_id_q;
    assign m1_ack     = (state_q == ST_RESP) &&  grant_id_q;
    assign m0_rdata   = m0_ack ? rdata_q : '0;
    assign m1_rdata   = m1_ack ? rdata_q : '0;
    assign m0_stall   = m0_req & ~m0_ack;
    assign grant_id   = grant_id_q;

endmodule
